// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ss_state_t;

    function automatic int ss_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Counter is sized to hold the step count itself, not just the last index.
    function automatic int ss_cnt_width(input int width, input int bpc);
        return $clog2(width / bpc + 1);
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full-subtractor cell: d = a - b - bi, with borrow-out bo.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, BPC bits per clock over WIDTH/BPC steps.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int S  = ss_steps(WIDTH, BPC);
    localparam int CW = ss_cnt_width(WIDTH, BPC);

    if ((WIDTH < 2) || (BPC < 1) || ((WIDTH % BPC) != 0)) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be >= 2 and a multiple of BPC");
    end

    ss_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] dsh_q, dsh_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [BPC:0]     borrow_s;
    logic [BPC-1:0]   d_s;
    logic [WIDTH-1:0] dsh_next_s;

    assign borrow_s[0] = brw_q;

    for (genvar i = 0; i < BPC; i++) begin : g_cell
        full_sub_cell u_cell (
            .a  (a_sh_q[i]),
            .b  (b_sh_q[i]),
            .bi (borrow_s[i]),
            .d  (d_s[i]),
            .bo (borrow_s[i+1])
        );
    end

    // New result bits enter at the top so the first (LSB) chunk ends up at bit 0.
    if (S == 1) begin : g_dsh_single
        assign dsh_next_s = d_s;
    end else begin : g_dsh_multi
        assign dsh_next_s = {d_s, dsh_q[WIDTH-1:BPC]};
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        dsh_d   = dsh_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> BPC;
                b_sh_d = b_sh_q >> BPC;
                dsh_d  = dsh_next_s;
                brw_d  = borrow_s[BPC];
                cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(S - 1)) begin
                    diff_d  = dsh_next_s;
                    bout_d  = borrow_s[BPC];
                    ovf_d   = borrow_s[BPC-1] ^ borrow_s[BPC];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            dsh_q   <= {WIDTH{1'b0}};
            brw_q   <= 1'b0;
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            dsh_q   <= dsh_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8/BPC=1 and WIDTH=4/BPC=2 instances against an arithmetic reference.
module tb_serial_subtractor;

    logic clk;
    logic rst_n;

    logic       s8_start, s8_bin, s8_busy, s8_done, s8_bout, s8_ovf;
    logic [7:0] s8_a, s8_b, s8_diff;
    logic       s4_start, s4_bin, s4_busy, s4_done, s4_bout, s4_ovf;
    logic [3:0] s4_a, s4_b, s4_diff;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8), .BPC(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .a(s8_a), .b(s8_b), .bin(s8_bin),
        .busy(s8_busy), .done(s8_done), .diff(s8_diff), .bout(s8_bout), .ovf(s8_ovf)
    );

    serial_subtractor #(.WIDTH(4), .BPC(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .a(s4_a), .b(s4_b), .bin(s4_bin),
        .busy(s4_busy), .done(s4_done), .diff(s4_diff), .bout(s4_bout), .ovf(s4_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, bout, diff[7:0]} from integer arithmetic on w-bit operands.
    function automatic logic [9:0] ref_sub(input int w, input int a, input int b, input int bin);
        int m, r, sa, sb, sr;
        logic [7:0] dd;
        logic bo, ov;
        m  = 1 << w;
        r  = a - b - bin;
        dd = 8'((r + m) % m);
        bo = (r < 0);
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        sr = sa - sb - bin;
        ov = (sr < -(m / 2)) || (sr >= m / 2);
        return {ov, bo, dd};
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output logic ov,
                       output int lat, output logic bsy, output logic [7:0] d_early);
        s8_a = a; s8_b = b; s8_bin = bin; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        bsy = s8_busy;
        d_early = s8_diff;
        lat = 0;
        while (s8_done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d = s8_diff; bo = s8_bout; ov = s8_ovf;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       output logic [3:0] d, output logic bo, output logic ov, output int lat);
        s4_a = a; s4_b = b; s4_bin = bin; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        lat = 0;
        while (s4_done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d = s4_diff; bo = s4_bout; ov = s4_ovf;
    endtask

    task automatic test_reset();
        logic [7:0] d, de; logic bo, ov, bsy; int lat;
        #3;
        checks++;
        if ({s8_busy, s8_done, s8_diff, s8_bout, s8_ovf} !== 11'd0) begin
            errors++; $display("FAIL reset_init8 got=%h exp=0", {s8_busy, s8_done, s8_diff, s8_bout, s8_ovf});
        end
        checks++;
        if ({s4_busy, s4_done, s4_diff, s4_bout, s4_ovf} !== 7'd0) begin
            errors++; $display("FAIL reset_init4 got=%h exp=0", {s4_busy, s4_done, s4_diff, s4_bout, s4_ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'hFF, 8'h00, 1'b0, d, bo, ov, lat, bsy, de);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s8_busy, s8_done, s8_diff, s8_bout, s8_ovf} !== 11'd0) begin
            errors++; $display("FAIL reset_async got=%h exp=0", {s8_busy, s8_done, s8_diff, s8_bout, s8_ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] d, de; logic bo, ov, bsy; int lat;
        op8(8'h5A, 8'h3C, 1'b0, d, bo, ov, lat, bsy, de);
        checks++;
        if ({ov, bo, d} !== {1'b0, 1'b0, 8'h1E}) begin
            errors++; $display("FAIL basic_result got=%b_%b_%h exp=0_0_1e", ov, bo, d);
        end
        checks++;
        if (lat !== 8 || bsy !== 1'b1) begin
            errors++; $display("FAIL basic_timing got lat=%0d busy=%b exp lat=8 busy=1", lat, bsy);
        end
        @(negedge clk);
        checks++;
        if ({s8_done, s8_busy, s8_diff} !== {1'b0, 1'b0, 8'h1E}) begin
            errors++; $display("FAIL basic_pulse_hold got done=%b busy=%b diff=%h exp 0 0 1e", s8_done, s8_busy, s8_diff);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] d, de; logic bo, ov, bsy; int lat;
        op8(8'h3C, 8'h5A, 1'b1, d, bo, ov, lat, bsy, de);
        checks++;
        if ({ov, bo, d} !== {1'b0, 1'b1, 8'hE1}) begin
            errors++; $display("FAIL borrow_result got=%b_%b_%h exp=0_1_e1", ov, bo, d);
        end
    endtask

    task automatic test_overflow_back_to_back();
        logic [7:0] d, de; logic bo, ov, bsy; int lat;
        op8(8'h80, 8'h01, 1'b0, d, bo, ov, lat, bsy, de);
        checks++;
        if ({ov, bo, d} !== {1'b1, 1'b0, 8'h7F}) begin
            errors++; $display("FAIL ovf1_result got=%b_%b_%h exp=1_0_7f", ov, bo, d);
        end
        op8(8'h7F, 8'hFF, 1'b0, d, bo, ov, lat, bsy, de);
        checks++;
        if (bsy !== 1'b1 || de !== 8'h7F) begin
            errors++; $display("FAIL b2b_accept got busy=%b diff=%h exp busy=1 diff=7f", bsy, de);
        end
        checks++;
        if ({ov, bo, d} !== {1'b1, 1'b1, 8'h80} || lat !== 8) begin
            errors++; $display("FAIL ovf2_result got=%b_%b_%h lat=%0d exp=1_1_80 lat=8", ov, bo, d, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] d, de, ra, rb; logic bo, ov, bsy, rbin; int lat;
        logic [9:0] exp;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            if (i == 0) rb = ra;
            if (i == 0) rbin = 1'b0;
            op8(ra, rb, rbin, d, bo, ov, lat, bsy, de);
            exp = ref_sub(8, int'(ra), int'(rb), int'(rbin));
            checks++;
            if ({ov, bo, d} !== exp || lat !== 8) begin
                errors++;
                $display("FAIL random a=%h b=%h bin=%b got=%b_%b_%h lat=%0d exp=%b_%b_%h lat=8",
                         ra, rb, rbin, ov, bo, d, lat, exp[9], exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_exhaustive4();
        logic [3:0] d; logic bo, ov; int lat; int bad;
        logic [9:0] exp;
        bad = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    op4(4'(ia), 4'(ib), 1'(ic), d, bo, ov, lat);
                    exp = ref_sub(4, ia, ib, ic);
                    checks++;
                    if ({ov, bo, d} !== {exp[9], exp[8], exp[3:0]} || lat !== 2) begin
                        errors++; bad++;
                        if (bad < 10)
                            $display("FAIL exhaustive4 a=%h b=%h bin=%0d got=%b_%b_%h lat=%0d exp=%b_%b_%h lat=2",
                                     ia, ib, ic, ov, bo, d, lat, exp[9], exp[8], exp[3:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_start_mid_run();
        int lat;
        logic [9:0] exp;
        exp = ref_sub(8, 'h91, 'h23, 0);
        s8_a = 8'h91; s8_b = 8'h23; s8_bin = 1'b0; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (2) @(negedge clk);
        s8_a = 8'h0F; s8_b = 8'hF0; s8_bin = 1'b1; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        lat = 3;
        while (s8_done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({s8_ovf, s8_bout, s8_diff} !== exp || lat !== 8) begin
            errors++; $display("FAIL mid_run_start got=%b_%b_%h lat=%0d exp=%b_%b_%h lat=8",
                               s8_ovf, s8_bout, s8_diff, lat, exp[9], exp[8], exp[7:0]);
        end
        @(negedge clk);
        checks++;
        if (s8_busy !== 1'b0 || s8_done !== 1'b0) begin
            errors++; $display("FAIL mid_run_no_queue got busy=%b done=%b exp 0 0", s8_busy, s8_done);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] d, de; logic bo, ov, bsy; int lat; int pulses;
        s8_a = 8'hC3; s8_b = 8'h11; s8_bin = 1'b0; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s8_busy, s8_done, s8_diff, s8_bout, s8_ovf} !== 11'd0) begin
            errors++; $display("FAIL reset_mid_op got=%h exp=0", {s8_busy, s8_done, s8_diff, s8_bout, s8_ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s8_done === 1'b1 || s8_busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL reset_abort got activity=%0d exp=0", pulses);
        end
        op8(8'h10, 8'h20, 1'b1, d, bo, ov, lat, bsy, de);
        checks++;
        if ({ov, bo, d} !== {1'b0, 1'b1, 8'hEF} || lat !== 8) begin
            errors++; $display("FAIL after_reset got=%b_%b_%h lat=%0d exp=0_1_ef lat=8", ov, bo, d, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s8_start = 1'b0; s8_a = 8'h00; s8_b = 8'h00; s8_bin = 1'b0;
        s4_start = 1'b0; s4_a = 4'h0; s4_b = 4'h0; s4_bin = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow_back_to_back();
        test_random();
        test_exhaustive4();
        test_start_mid_run();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
